// File: rtl/rect_pkg.sv
// Shared types for the rectangle burst writer: FSM state encoding and draw modes.
package rect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REQ,
    DATA,
    NEXT,
    DONE
  } state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

endpackage

// File: rtl/rect_row_splitter.sv
// Splits a row segment into bursts of at most MAX_BURST pixels, left to right.
// Holds the current burst column/remainder; col_nxt exposes the column the next cycle will hold.
module rect_row_splitter
  import rect_pkg::*;
#(
  parameter int CW        = 11,
  parameter int LEN_W     = 10,
  parameter int MAX_BURST = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [CW-1:0]    load_col,
  input  logic [CW-1:0]    load_rem,
  output logic [CW-1:0]    col_nxt,
  output logic [LEN_W-1:0] burst_len,
  output logic             more
);
  localparam logic [CW-1:0]    MAXB = CW'(MAX_BURST);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_BURST);

  logic [CW-1:0] col_r, rem_r, rem_d;

  always_comb begin
    col_nxt = col_r;
    rem_d   = rem_r;
    if (load) begin
      col_nxt = load_col;
      rem_d   = load_rem;
    end else if (advance) begin
      col_nxt = col_r + MAXB;
      rem_d   = rem_r - MAXB;
    end
  end

  // Remainder above one burst means at least one more burst follows in this segment.
  assign more = (rem_r > MAXB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r     <= '0;
      rem_r     <= '0;
      burst_len <= '0;
    end else begin
      col_r     <= col_nxt;
      rem_r     <= rem_d;
      burst_len <= (rem_d > MAXB) ? LMAX : LEN_W'(rem_d);
    end
  end

endmodule

// File: rtl/rect_burst_writer.sv
// Rectangle renderer: latches a command, clips it to the screen and walks rows/segments,
// issuing SDRAM write bursts of solid colour (fill or 1-pixel outline).
module rect_burst_writer
  import rect_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int MAX_BURST = 128,
  parameter int LEN_W     = 10,
  parameter int ADDR_W    = 22,
  parameter int PIX_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [COORD_W-1:0] x_pixel,
  input  logic [COORD_W-1:0] y_pixel,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic [PIX_W-1:0]   color,
  output logic               busy,
  output logic               done,
  output logic               write_burst_req,
  output logic [ADDR_W-1:0]  write_burst_addr,
  output logic [LEN_W-1:0]   write_burst_len,
  input  logic               write_burst_data_req,
  output logic [PIX_W-1:0]   write_burst_data,
  input  logic               write_burst_data_finish
);
  localparam int            CW    = COORD_W + 1;
  localparam logic [CW-1:0] SCR_W = CW'(SCREEN_W);
  localparam logic [CW-1:0] SCR_H = CW'(SCREEN_H);

  state_t state, state_nxt;

  logic               mode_r;
  logic [COORD_W-1:0] x_r, y_r, w_r, h_r;
  logic [PIX_W-1:0]   color_r;
  logic [CW-1:0]      row_r, row_d, row_inc;
  logic               seg_r, seg_d;

  logic [CW-1:0]      x_sum, y_sum, x_end, y_end, span, x_right;
  logic               empty, right_ok, full_cur, full_inc;

  logic               sp_load, sp_adv, sp_more;
  logic [CW-1:0]      ld_col, ld_rem, col_nxt;
  logic [LEN_W-1:0]   burst_len;
  logic [ADDR_W-1:0]  addr_r;

  // Clipping runs one bit wider than the coordinates so x+width cannot wrap.
  assign x_sum    = CW'(x_r) + CW'(w_r);
  assign y_sum    = CW'(y_r) + CW'(h_r);
  assign x_end    = (x_sum > SCR_W) ? SCR_W : x_sum;
  assign y_end    = (y_sum > SCR_H) ? SCR_H : y_sum;
  assign span     = x_end - CW'(x_r);
  assign x_right  = x_sum - CW'(1);
  assign empty    = (w_r == '0) || (h_r == '0) || (CW'(x_r) >= SCR_W) || (CW'(y_r) >= SCR_H);
  assign right_ok = (w_r > COORD_W'(1)) && (x_sum <= SCR_W);
  assign row_inc  = row_r + CW'(1);

  // Full-width rows: every row in fill mode, top and last visible row in outline mode.
  assign full_cur = (mode_r == MODE_FILL) || (row_r == CW'(y_r)) || (row_r == y_end - CW'(1));
  assign full_inc = (mode_r == MODE_FILL) || (row_inc == y_end - CW'(1));

  always_comb begin
    state_nxt = state;
    sp_load   = 1'b0;
    sp_adv    = 1'b0;
    ld_col    = CW'(x_r);
    ld_rem    = span;
    row_d     = row_r;
    seg_d     = seg_r;
    unique case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: begin
        if (empty) begin
          state_nxt = DONE;
        end else begin
          sp_load   = 1'b1;
          row_d     = CW'(y_r);
          seg_d     = 1'b0;
          state_nxt = REQ;
        end
      end
      REQ:   if (write_burst_data_req) state_nxt = DATA;
      DATA:  if (write_burst_data_finish) state_nxt = NEXT;
      NEXT: begin
        if (sp_more) begin
          sp_adv    = 1'b1;
          state_nxt = REQ;
        end else if (!full_cur && !seg_r && right_ok) begin
          sp_load   = 1'b1;
          ld_col    = x_right;
          ld_rem    = CW'(1);
          seg_d     = 1'b1;
          state_nxt = REQ;
        end else if (row_inc >= y_end) begin
          state_nxt = DONE;
        end else begin
          sp_load   = 1'b1;
          ld_rem    = full_inc ? span : CW'(1);
          row_d     = row_inc;
          seg_d     = 1'b0;
          state_nxt = REQ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_r  <= 1'b0;
      x_r     <= '0;
      y_r     <= '0;
      w_r     <= '0;
      h_r     <= '0;
      color_r <= '0;
      row_r   <= '0;
      seg_r   <= 1'b0;
      addr_r  <= '0;
    end else begin
      state  <= state_nxt;
      row_r  <= row_d;
      seg_r  <= seg_d;
      addr_r <= ADDR_W'(row_d) * ADDR_W'(SCREEN_W) + ADDR_W'(col_nxt);
      if (state == IDLE && start) begin
        mode_r  <= mode;
        x_r     <= x_pixel;
        y_r     <= y_pixel;
        w_r     <= width;
        h_r     <= height;
        color_r <= color;
      end
    end
  end

  rect_row_splitter #(
    .CW        (CW),
    .LEN_W     (LEN_W),
    .MAX_BURST (MAX_BURST)
  ) u_split (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sp_load),
    .advance   (sp_adv),
    .load_col  (ld_col),
    .load_rem  (ld_rem),
    .col_nxt   (col_nxt),
    .burst_len (burst_len),
    .more      (sp_more)
  );

  assign busy             = (state != IDLE) && (state != DONE);
  assign done             = (state == DONE);
  assign write_burst_req  = (state == REQ);
  assign write_burst_addr = addr_r;
  assign write_burst_len  = burst_len;
  assign write_burst_data = ((state == REQ || state == DATA) && write_burst_data_req) ? color_r : '0;

endmodule

// File: tb/tb_rect_burst_writer.sv
// Bench for rect_burst_writer: directed plan cases plus random commands checked
// against a queue-based burst model, with a randomized arbiter on the burst port.
module tb_rect_burst_writer;
  localparam int COORD_W = 10, SCREEN_W = 640, SCREEN_H = 480, MAX_BURST = 128;
  localparam int LEN_W = 10, ADDR_W = 22, PIX_W = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [COORD_W-1:0] x_pixel = '0, y_pixel = '0, width = '0, height = '0;
  logic [PIX_W-1:0] color = '0;
  logic busy, done, write_burst_req;
  logic [ADDR_W-1:0] write_burst_addr;
  logic [LEN_W-1:0] write_burst_len;
  logic write_burst_data_req = 1'b0, write_burst_data_finish = 1'b0;
  logic [PIX_W-1:0] write_burst_data;

  rect_burst_writer #(
    .COORD_W(COORD_W), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .MAX_BURST(MAX_BURST),
    .LEN_W(LEN_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .width(width), .height(height), .color(color),
    .busy(busy), .done(done), .write_burst_req(write_burst_req),
    .write_burst_addr(write_burst_addr), .write_burst_len(write_burst_len),
    .write_burst_data_req(write_burst_data_req), .write_burst_data(write_burst_data),
    .write_burst_data_finish(write_burst_data_finish)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int exp_addr[$], exp_len[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic push(input int a, input int l);
    exp_addr.push_back(a);
    exp_len.push_back(l);
  endtask

  // Reference: enumerate segments per visible row, then cut each into MAX_BURST pieces.
  task automatic add_seg(input int r, input int c, input int n);
    int l;
    while (n > 0) begin
      l = (n > MAX_BURST) ? MAX_BURST : n;
      push((r * SCREEN_W + c) % (1 << ADDR_W), l);
      c += l;
      n -= l;
    end
  endtask

  task automatic model(input int m, input int x, input int y, input int w, input int h);
    int xe, ye;
    exp_addr.delete();
    exp_len.delete();
    if (w == 0 || h == 0 || x >= SCREEN_W || y >= SCREEN_H) return;
    xe = (x + w < SCREEN_W) ? x + w : SCREEN_W;
    ye = (y + h < SCREEN_H) ? y + h : SCREEN_H;
    for (int r = y; r < ye; r++) begin
      if (m == 0 || r == y || r == ye - 1) add_seg(r, x, xe - x);
      else begin
        add_seg(r, x, 1);
        if (x + w - 1 < SCREEN_W && w > 1) add_seg(r, x + w - 1, 1);
      end
    end
  endtask

  task automatic issue(input int m, input int x, input int y, input int w, input int h, input int col);
    mode = m[0]; x_pixel = COORD_W'(x); y_pixel = COORD_W'(y);
    width = COORD_W'(w); height = COORD_W'(h); color = PIX_W'(col);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the accepted command must not follow them.
    mode = ~mode; x_pixel = COORD_W'($urandom); y_pixel = COORD_W'($urandom);
    width = COORD_W'($urandom); height = COORD_W'($urandom); color = PIX_W'($urandom);
  endtask

  // Arbiter side of one burst: random grant delay, gaps, optional overrun beat
  // and optional finish coincident with the last beat.
  task automatic do_burst(input int len, input logic [PIX_W-1:0] col, input bit mid_start);
    int nb;
    bit sim, fin;
    if (mid_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("req_hold_start", write_burst_req, 1);
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("req_hold", write_burst_req, 1);
    end
    nb  = len + (($urandom_range(0, 4) == 0) ? 1 : 0);
    sim = ($urandom_range(0, 1) == 1);
    fin = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        write_burst_data_req = 1'b0;
        #1 chk("data_idle", write_burst_data, 0);
        @(negedge clk);
      end
      fin = sim && (i > 0) && (i == nb - 1);
      write_burst_data_req = 1'b1;
      write_burst_data_finish = fin;
      #1 chk("data_beat", write_burst_data, col);
      @(negedge clk);
      if (i == 0) chk("req_drop", write_burst_req, 0);
    end
    write_burst_data_req = 1'b0;
    write_burst_data_finish = 1'b0;
    if (!fin) begin
      write_burst_data_finish = 1'b1;
      @(negedge clk);
      write_burst_data_finish = 1'b0;
    end
  endtask

  task automatic run_cmd(input int m, input int x, input int y, input int w, input int h,
                         input int col, input bit mid_start);
    int cyc;
    bit ok, first;
    int l;
    issue(m, x, y, w, h, col);
    chk("busy_rise", busy, 1);
    cyc = 0; ok = 1'b0; first = 1'b1;
    while (cyc < 20000) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (write_burst_req) begin
        if (exp_addr.size() == 0) begin
          chk("extra_burst", write_burst_req, 0);
          break;
        end
        chk("busy_in_req", busy, 1);
        chk("burst_addr", write_burst_addr, exp_addr.pop_front());
        l = exp_len.pop_front();
        chk("burst_len", write_burst_len, l);
        do_burst(l, PIX_W'(col), mid_start && first);
        first = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", ok, 1);
    chk("bursts_left", exp_addr.size(), 0);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic run_empty(input int m, input int x, input int y, input int w, input int h);
    issue(m, x, y, w, h, 16'h1234);
    chk("empty_busy1", busy, 1);
    chk("empty_done1", done, 0);
    chk("empty_req1", write_burst_req, 0);
    @(negedge clk);
    chk("empty_done2", done, 1);
    chk("empty_busy2", busy, 0);
    chk("empty_req2", write_burst_req, 0);
    @(negedge clk);
    chk("empty_done3", done, 0);
    chk("empty_req3", write_burst_req, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", write_burst_req, 0);
    chk("rst_addr", write_burst_addr, 0);
    chk("rst_len", write_burst_len, 0);
    chk("rst_data", write_burst_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed plan cases with hand-derived bursts.
    exp_addr.delete(); exp_len.delete();
    push(12810, 4); push(13450, 4);
    run_cmd(0, 10, 20, 4, 2, 16'hF800, 0);

    exp_addr.delete(); exp_len.delete();
    push(0, 128); push(128, 128); push(256, 44);
    run_cmd(0, 0, 0, 300, 1, 16'h07E0, 0);

    exp_addr.delete(); exp_len.delete();
    push(306550, 10); push(307190, 10);
    run_cmd(0, 630, 478, 20, 5, 16'h001F, 0);

    exp_addr.delete(); exp_len.delete();
    push(3205, 3); push(3845, 1); push(3847, 1); push(4485, 3);
    run_cmd(1, 5, 5, 3, 3, 16'hABCD, 0);

    exp_addr.delete(); exp_len.delete();
    push(7035, 5); push(7675, 1); push(8315, 5);
    run_cmd(1, 635, 10, 10, 3, 16'h5555, 0);

    run_empty(0, 10, 10, 0, 4);
    run_empty(1, 640, 10, 5, 4);
    run_empty(0, 10, 10, 5, 0);

    // Start pulsed mid-command must be ignored.
    exp_addr.delete(); exp_len.delete();
    push(3205, 3); push(3845, 1); push(3847, 1); push(4485, 3);
    run_cmd(1, 5, 5, 3, 3, 16'h0F0F, 1);

    // Reset during a DATA phase of the 300-pixel fill.
    issue(0, 0, 0, 300, 1, 16'h07E0);
    for (int k = 0; k < 10 && !write_burst_req; k++) @(negedge clk);
    chk("rstmid_req_seen", write_burst_req, 1);
    chk("rstmid_addr", write_burst_addr, 0);
    write_burst_data_req = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstmid_data", write_burst_data, 16'h07E0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_req", write_burst_req, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_dout", write_burst_data, 0);
    chk("rstmid_len", write_burst_len, 0);
    @(negedge clk);
    write_burst_data_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    exp_addr.delete(); exp_len.delete();
    push(12810, 4); push(13450, 4);
    run_cmd(0, 10, 20, 4, 2, 16'hF800, 0);

    // Random commands against the reference model.
    for (int t = 0; t < 12; t++) begin
      int m, x, y, w, h, c;
      m = $urandom_range(0, 1);
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(500, 1023) : $urandom_range(0, 600);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 1023) : $urandom_range(0, 470);
      w = $urandom_range(0, 300);
      h = $urandom_range(0, 6);
      c = $urandom_range(1, 65535);
      model(m, x, y, w, h);
      run_cmd(m, x, y, w, h, c, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rect_burst_writer.md
Name: rect_burst_writer

Overview:
Parametrised rectangle renderer for the SDRAM frame buffer. It latches a rectangle command on a start pulse and clips it to the screen. Each clipped row is split into write bursts of at most MAX_BURST pixels. Supports solid-fill and 1-pixel outline modes, and sits between the graphics command decoder and the SDRAM write-burst arbiter port.

Parameters:
- COORD_W, 10, width of x/y/width/height inputs.
- SCREEN_W, 640, visible pixels per line (also the frame-buffer line stride).
- SCREEN_H, 480, visible lines.
- MAX_BURST, 128, maximum pixels per write burst.
- LEN_W, 10, width of write_burst_len; must hold MAX_BURST.
- ADDR_W, 22, frame-buffer word address width.
- PIX_W, 16, pixel width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle command strobe; ignored while busy.
- mode  in  1  0 = solid fill, 1 = outline.
- x_pixel, y_pixel  in  COORD_W  top-left corner.
- width, height  in  COORD_W  size in pixels.
- color  in  PIX_W  fill colour.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- write_burst_req  out  1  burst request to the arbiter.
- write_burst_addr  out  ADDR_W  burst start address, computed as row*SCREEN_W + col.
- write_burst_len  out  LEN_W  burst length in pixels, 1..MAX_BURST.
- write_burst_data_req  in  1  arbiter consumes one pixel in each cycle this is high.
- write_burst_data  out  PIX_W  pixel data.
- write_burst_data_finish  in  1  one-cycle pulse after the last beat of a burst.

Behaviour:
- Reset values: all outputs 0; state IDLE; all latched command registers 0.
- Command acceptance:
  - start is accepted only in IDLE; all inputs are latched on that cycle.
  - Later input changes have no effect on the accepted command.
- Clipping, performed in the SETUP state:
  - x_end = min(x+width, SCREEN_W); y_end = min(y+height, SCREEN_H).
  - Sums are computed at COORD_W+1 bits, so no wrap-around occurs.
- Empty command: if width==0, height==0, x>=SCREEN_W or y>=SCREEN_H, then no burst is issued, done pulses 2 cycles after start, and busy is high for 1 cycle.
- Segments per row:
  - Fill mode: every row is one segment [x, x_end).
  - Outline mode, top row (y) and last row (y_end-1): one segment [x, x_end).
  - Outline mode, middle rows: segment {x}, then, if x+width-1 < SCREEN_W and width>1, segment {x+width-1}. A right edge clipped off-screen is not drawn.
- Burst splitting: each segment is split into bursts of len = min(remaining, MAX_BURST), issued left to right.
- State machine:
  - IDLE -> SETUP on accepted start.
  - SETUP -> REQ, or -> DONE if the command is empty.
  - REQ:
    - write_burst_req, addr and len are registered and stable.
    - req is held until the first cycle write_burst_data_req is high, then deasserted the next cycle -> DATA.
    - Data beats in that first cycle count.
  - DATA:
    - write_burst_data = latched colour whenever write_burst_data_req is high, 0 otherwise.
    - Beats are counted; finish -> NEXT.
  - NEXT:
    - Advance the burst/segment/row pointer, computing the next addr in one cycle.
    - Goes to REQ if work remains, else DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Overrun: if the beat count reaches len before finish, further data_req beats still output the colour. finish remains the only burst terminator.
- Simultaneous events: finish together with data_req in the same cycle counts the beat, then proceeds to NEXT.
- start during busy is ignored; no queuing.
- Reset mid-burst: everything returns to reset values immediately; the arbiter sees req drop.
- Address arithmetic: row*SCREEN_W is a constant multiply into ADDR_W bits; the result is truncated to ADDR_W.

Decomposition:
- Package rect_pkg:
  - state encoding (IDLE, SETUP, REQ, DATA, NEXT, DONE);
  - MODE_FILL=0, MODE_OUTLINE=1.
- Sub-module rect_row_splitter: given the segment start and remaining length, produces the burst col/len and the next remainder. It is combinational plus a registered remainder.
- The FSM and row/segment walking stay in the top module.

Test Plan:
1. Fill x=10,y=20,w=4,h=2,color=16'hF800:
   - bursts addr 12810 len 4, then addr 13450 len 4;
   - 8 data beats of F800;
   - done once.
2. Fill x=0,y=0,w=300,h=1:
   - bursts (0,128), (128,128), (256,44);
   - 300 beats total.
3. Clip x=630,y=478,w=20,h=5:
   - rows 478 and 479 only, len 10 each;
   - addrs 306550 and 307190.
4. Outline x=5,y=5,w=3,h=3:
   - (3205,3); (3845,1); (3847,1); (4485,3).
5. Empty and ignored commands:
   - width=0 -> done 2 cycles after start, write_burst_req never asserted;
   - start pulsed while busy -> ignored, original command completes unchanged.
6. Assert rst_n low during DATA of test 2:
   - write_burst_req, busy and done go 0 immediately;
   - a new start after reset executes correctly.
